// File: rtl/useq_pkg.sv
// Shared types for the micro-program sequencer: FSM states, jump-condition
// encodings and the captured microinstruction control fields.
package useq_pkg;

  localparam int AW_DEF = 22;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } useq_state_e;

  typedef enum logic [1:0] {
    JT_MEQ = 2'b00,
    JT_IEQ = 2'b01,
    JT_IGT = 2'b10,
    JT_ILS = 2'b11
  } jmp_type_e;

  typedef struct packed {
    jmp_type_e jmptype;
    logic      incpcjta;
    logic      noc;
    logic      call;
    logic      ret;
    logic      halt;
  } ui_ctrl_t;

  // Flags are packed {ILS, IGT, IEQ, MEQ} so the jump type indexes them directly.
  function automatic logic flag_sel(input jmp_type_e jt, input logic [3:0] flags);
    return flags[jt];
  endfunction

endpackage

// File: rtl/useq_ret_stack.sv
// Return-address LIFO for micro-calls; top of stack is always visible on dout.
module useq_ret_stack #(
  parameter int AW    = 22,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW:0]   cnt;
  logic [PW-1:0] top_idx;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = cnt[PW-1:0] - PW'(1);
  assign dout    = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (push && !full)   cnt <= cnt + (PW+1)'(1);
    else if (pop && !empty)   cnt <= cnt - (PW+1)'(1);
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[cnt[PW-1:0]] <= din;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC owner: fetch/execute handshake with the control store, flag-conditioned
// jumps, call/return through useq_ret_stack, and halt.
//
//   state   | meaning
//   S_IDLE  | after reset, waiting for START
//   S_FETCH | CS_REQ high, waiting for CS_RDY to capture the microinstruction
//   S_EXEC  | decode captured instruction (held while STALL), pick next UPC
//   S_HALT  | stopped by UI_HALT or stack error, waiting for START
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int            AW         = AW_DEF,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] START_ADDR = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          STALL,
  input  logic          CS_RDY,
  input  logic [1:0]    UI_JMPTYPE,
  input  logic [AW-1:0] UI_JTA,
  input  logic          UI_INCPCJTA,
  input  logic          UI_NOC,
  input  logic          UI_CALL,
  input  logic          UI_RET,
  input  logic          UI_HALT,
  input  logic          MEQ,
  input  logic          IEQ,
  input  logic          IGT,
  input  logic          ILS,
  input  logic          FLAG_LD,
  output logic          CS_REQ,
  output logic [AW-1:0] CS_ADDR,
  output logic [AW-1:0] UPC,
  output logic          BUSY,
  output logic          HALTED,
  output logic          STK_ERR
);

  useq_state_e   state, state_nxt;
  logic [AW-1:0] upc, upc_nxt, upc_inc, ir_jta, stk_top;
  ui_ctrl_t      ir;
  logic [3:0]    flags;
  logic          cs_req, stk_err, err_set;
  logic          stk_push, stk_pop, stk_clr, stk_full, stk_empty;

  assign upc_inc = upc + AW'(1);

  useq_ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (upc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      upc     <= START_ADDR;
      cs_req  <= 1'b0;
      stk_err <= 1'b0;
      flags   <= '0;
      ir      <= '0;
      ir_jta  <= '0;
    end else begin
      state  <= state_nxt;
      upc    <= upc_nxt;
      cs_req <= (state_nxt == S_FETCH);
      if (stk_clr)      stk_err <= 1'b0;
      else if (err_set) stk_err <= 1'b1;
      if (FLAG_LD) flags <= {ILS, IGT, IEQ, MEQ};
      if (state == S_FETCH && CS_RDY) begin
        ir     <= '{jmptype: jmp_type_e'(UI_JMPTYPE), incpcjta: UI_INCPCJTA,
                    noc: UI_NOC, call: UI_CALL, ret: UI_RET, halt: UI_HALT};
        ir_jta <= UI_JTA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (START) begin
          upc_nxt   = START_ADDR;
          stk_clr   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (CS_RDY) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!STALL) begin
          state_nxt = S_FETCH;
          if (ir.call && ir.ret) begin
            err_set   = 1'b1;
            state_nxt = S_HALT;
          end else if (ir.halt) begin
            state_nxt = S_HALT;
          end else if (ir.ret) begin
            if (stk_empty) begin
              err_set   = 1'b1;
              state_nxt = S_HALT;
            end else begin
              stk_pop = 1'b1;
              upc_nxt = stk_top;
            end
          end else if (ir.call) begin
            if (stk_full) begin
              err_set   = 1'b1;
              state_nxt = S_HALT;
            end else begin
              stk_push = 1'b1;
              upc_nxt  = ir_jta;
            end
          end else if (ir.incpcjta && (ir.noc || flag_sel(ir.jmptype, flags))) begin
            upc_nxt = ir_jta;
          end else begin
            upc_nxt = upc_inc;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign CS_REQ  = cs_req;
  assign CS_ADDR = upc;
  assign UPC     = upc;
  assign BUSY    = (state == S_FETCH) || (state == S_EXEC);
  assign HALTED  = (state == S_HALT);
  assign STK_ERR = stk_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: hand-computed micro-PC sequences covering
// jumps, call/return, stall, handshake delay, wrap, stack errors and async reset.
module tb_micro_sequencer;
  localparam int            AW = 22;
  localparam logic [AW-1:0] SA = 22'h000010;

  logic          CLK = 1'b0, RST = 1'b1, START = 1'b0, STALL = 1'b0, CS_RDY = 1'b0;
  logic [1:0]    UI_JMPTYPE = '0;
  logic [AW-1:0] UI_JTA = '0;
  logic          UI_INCPCJTA = 0, UI_NOC = 0, UI_CALL = 0, UI_RET = 0, UI_HALT = 0;
  logic          MEQ = 0, IEQ = 0, IGT = 0, ILS = 0, FLAG_LD = 0;
  logic          CS_REQ, BUSY, HALTED, STK_ERR;
  logic [AW-1:0] CS_ADDR, UPC;
  int checks = 0, failures = 0;

  micro_sequencer #(.AW(AW), .DEPTH(4), .START_ADDR(SA)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STALL(STALL), .CS_RDY(CS_RDY),
    .UI_JMPTYPE(UI_JMPTYPE), .UI_JTA(UI_JTA), .UI_INCPCJTA(UI_INCPCJTA),
    .UI_NOC(UI_NOC), .UI_CALL(UI_CALL), .UI_RET(UI_RET), .UI_HALT(UI_HALT),
    .MEQ(MEQ), .IEQ(IEQ), .IGT(IGT), .ILS(ILS), .FLAG_LD(FLAG_LD),
    .CS_REQ(CS_REQ), .CS_ADDR(CS_ADDR), .UPC(UPC), .BUSY(BUSY),
    .HALTED(HALTED), .STK_ERR(STK_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic clear_ui();
    UI_JMPTYPE = '0; UI_JTA = '0; UI_INCPCJTA = 0; UI_NOC = 0;
    UI_CALL = 0; UI_RET = 0; UI_HALT = 0;
  endtask

  // Presents one microinstruction in FETCH, then lets EXEC resolve without stall.
  task automatic run_instr(input logic [1:0] jt, input logic [AW-1:0] jta,
                           input logic inc, input logic noc, input logic call,
                           input logic ret, input logic hlt);
    UI_JMPTYPE = jt; UI_JTA = jta; UI_INCPCJTA = inc; UI_NOC = noc;
    UI_CALL = call; UI_RET = ret; UI_HALT = hlt;
    CS_RDY = 1'b1;
    tick();
    CS_RDY = 1'b0;
    clear_ui();
    tick();
  endtask

  task automatic latch_flags(input logic [3:0] f);
    {ILS, IGT, IEQ, MEQ} = f;
    FLAG_LD = 1'b1;
    tick();
    FLAG_LD = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
    checks++;
    if ({CS_REQ, BUSY, HALTED, STK_ERR} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: req/busy/halt/err=%b expected 0000", {CS_REQ, BUSY, HALTED, STK_ERR});
    end
    checks++;
    if (UPC !== SA || CS_ADDR !== SA) begin
      failures++;
      $display("FAIL reset_upc: UPC=%h CS_ADDR=%h expected %h", UPC, CS_ADDR, SA);
    end
    do_start();
    checks++;
    if (CS_REQ !== 1'b1 || BUSY !== 1'b1 || CS_ADDR !== SA) begin
      failures++;
      $display("FAIL start_fetch: req=%b busy=%b addr=%h expected 1 1 %h", CS_REQ, BUSY, CS_ADDR, SA);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    do_start();
    run_instr(2'b00, 22'd11, 1, 1, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd11) begin
      failures++;
      $display("FAIL uncond_jump: CS_ADDR=%0d expected 11", CS_ADDR);
    end
    run_instr(2'b10, 22'd99, 1, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd12 || CS_REQ !== 1'b1) begin
      failures++;
      $display("FAIL igt_not_taken: CS_ADDR=%0d req=%b expected 12 1", CS_ADDR, CS_REQ);
    end
  endtask

  task automatic test_taken_jump();
    apply_reset();
    latch_flags(4'b0100);
    do_start();
    run_instr(2'b00, 22'd3, 1, 1, 0, 0, 0);
    run_instr(2'b10, 22'd3, 1, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd3) begin
      failures++;
      $display("FAIL igt_taken: CS_ADDR=%0d expected 3", CS_ADDR);
    end
    run_instr(2'b00, 22'd60, 1, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd4) begin
      failures++;
      $display("FAIL meq_not_taken: CS_ADDR=%0d expected 4", CS_ADDR);
    end
    run_instr(2'b00, 22'd1, 1, 1, 0, 0, 0);
    run_instr(2'b10, 22'd77, 0, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd2) begin
      failures++;
      $display("FAIL incpcjta_zero: CS_ADDR=%0d expected 2", CS_ADDR);
    end
    // Flags reloaded during EXEC only affect the following instruction.
    UI_JMPTYPE = 2'b10; UI_JTA = 22'd50; UI_INCPCJTA = 1;
    CS_RDY = 1'b1;
    tick();
    CS_RDY = 1'b0;
    clear_ui();
    {ILS, IGT, IEQ, MEQ} = 4'b0000;
    FLAG_LD = 1'b1;
    tick();
    FLAG_LD = 1'b0;
    checks++;
    if (CS_ADDR !== 22'd50) begin
      failures++;
      $display("FAIL flag_ld_same_cycle: CS_ADDR=%0d expected 50", CS_ADDR);
    end
    run_instr(2'b10, 22'd70, 1, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd51) begin
      failures++;
      $display("FAIL flag_ld_next_instr: CS_ADDR=%0d expected 51", CS_ADDR);
    end
    run_instr(2'b11, 22'd90, 1, 0, 0, 0, 0);
    latch_flags(4'b1000);
    run_instr(2'b11, 22'd90, 1, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd90) begin
      failures++;
      $display("FAIL ils_taken: CS_ADDR=%0d expected 90", CS_ADDR);
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    do_start();
    run_instr(2'b00, 22'd8, 1, 1, 0, 0, 0);
    run_instr(2'b00, 22'd40, 0, 0, 1, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd40) begin
      failures++;
      $display("FAIL call: CS_ADDR=%0d expected 40", CS_ADDR);
    end
    run_instr(2'b00, 22'd0, 0, 0, 0, 1, 0);
    checks++;
    if (CS_ADDR !== 22'd9 || STK_ERR !== 1'b0) begin
      failures++;
      $display("FAIL ret: CS_ADDR=%0d err=%b expected 9 0", CS_ADDR, STK_ERR);
    end
    for (int i = 0; i < 4; i++) run_instr(2'b00, 22'(100 + i), 0, 0, 1, 0, 0);
    checks++;
    if (CS_ADDR !== 22'd103 || HALTED !== 1'b0) begin
      failures++;
      $display("FAIL nested_four: CS_ADDR=%0d halted=%b expected 103 0", CS_ADDR, HALTED);
    end
    run_instr(2'b00, 22'd200, 0, 0, 1, 0, 0);
    checks++;
    if ({STK_ERR, HALTED, BUSY, CS_REQ} !== 4'b1100 || UPC !== 22'd103) begin
      failures++;
      $display("FAIL overflow: err/halt/busy/req=%b UPC=%0d expected 1100 103", {STK_ERR, HALTED, BUSY, CS_REQ}, UPC);
    end
    do_start();
    checks++;
    if (STK_ERR !== 1'b0 || HALTED !== 1'b0 || CS_ADDR !== SA) begin
      failures++;
      $display("FAIL restart: err=%b halted=%b addr=%h expected 0 0 %h", STK_ERR, HALTED, CS_ADDR, SA);
    end
    run_instr(2'b00, 22'd0, 0, 0, 0, 1, 0);
    checks++;
    if (STK_ERR !== 1'b1 || HALTED !== 1'b1 || UPC !== SA) begin
      failures++;
      $display("FAIL underflow: err=%b halted=%b UPC=%h expected 1 1 %h", STK_ERR, HALTED, UPC, SA);
    end
    do_start();
    run_instr(2'b00, 22'd0, 0, 0, 0, 0, 1);
    checks++;
    if (HALTED !== 1'b1 || STK_ERR !== 1'b0 || UPC !== SA) begin
      failures++;
      $display("FAIL halt: halted=%b err=%b UPC=%h expected 1 0 %h", HALTED, STK_ERR, UPC, SA);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    do_start();
    CS_RDY = 1'b1;
    tick();
    CS_RDY = 1'b0;
    STALL = 1'b1;
    UI_INCPCJTA = 1; UI_NOC = 1; UI_JTA = 22'd500;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (UPC !== SA || CS_REQ !== 1'b0 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: UPC=%h req=%b busy=%b expected %h 0 1", i, UPC, CS_REQ, BUSY, SA);
      end
    end
    STALL = 1'b0;
    clear_ui();
    tick();
    checks++;
    if (UPC !== SA + 22'd1 || CS_REQ !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: UPC=%h req=%b expected %h 1", UPC, CS_REQ, SA + 22'd1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (CS_REQ !== 1'b1 || CS_ADDR !== SA + 22'd1) begin
        failures++;
        $display("FAIL rdy_delay[%0d]: req=%b addr=%h expected 1 %h", i, CS_REQ, CS_ADDR, SA + 22'd1);
      end
    end
    run_instr(2'b00, 22'd0, 0, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== SA + 22'd2) begin
      failures++;
      $display("FAIL after_delay: CS_ADDR=%h expected %h", CS_ADDR, SA + 22'd2);
    end
  endtask

  task automatic test_wrap_conflict();
    apply_reset();
    do_start();
    run_instr(2'b00, 22'h3FFFFF, 1, 1, 0, 0, 0);
    run_instr(2'b00, 22'd0, 0, 0, 0, 0, 0);
    checks++;
    if (CS_ADDR !== 22'h000000) begin
      failures++;
      $display("FAIL wrap: CS_ADDR=%h expected 000000", CS_ADDR);
    end
    run_instr(2'b00, 22'd5, 1, 1, 0, 0, 0);
    run_instr(2'b00, 22'd9, 0, 0, 1, 1, 0);
    checks++;
    if (STK_ERR !== 1'b1 || HALTED !== 1'b1 || UPC !== 22'd5) begin
      failures++;
      $display("FAIL call_ret_conflict: err=%b halted=%b UPC=%0d expected 1 1 5", STK_ERR, HALTED, UPC);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_start();
    run_instr(2'b00, 22'h2A, 1, 1, 0, 0, 0);
    #2;
    RST = 1'b1; START = 1'b1; CS_RDY = 1'b1;
    #1;
    checks++;
    if ({CS_REQ, BUSY, HALTED, STK_ERR} !== 4'b0000 || UPC !== SA) begin
      failures++;
      $display("FAIL async_reset: req/busy/halt/err=%b UPC=%h expected 0000 %h", {CS_REQ, BUSY, HALTED, STK_ERR}, UPC, SA);
    end
    tick();
    checks++;
    if (CS_REQ !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL rst_over_start: req=%b busy=%b expected 0 0", CS_REQ, BUSY);
    end
    RST = 1'b0; CS_RDY = 1'b0; START = 1'b0;
    tick();
    do_start();
    checks++;
    if (CS_REQ !== 1'b1 || CS_ADDR !== SA) begin
      failures++;
      $display("FAIL start_after_rst: req=%b addr=%h expected 1 %h", CS_REQ, CS_ADDR, SA);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken_jump();
    test_call_ret();
    test_stall();
    test_wrap_conflict();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
